// File: rtl/sram_sp_4096x16.sv
// Single-port synchronous SRAM, 4096x16, with per-word written flags so that
// never-written (or reset-invalidated) words read back as zero.
module sram_sp_4096x16 #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 16,
  parameter int DEPTH  = 2**ADDR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] A,
  input  logic [DATA_W-1:0] DI,
  output logic [DATA_W-1:0] DO,
  input  logic              WEB,
  input  logic              CS,
  input  logic              OE
);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DEPTH-1:0]  written;
  logic [DATA_W-1:0] dout_q;
  logic              wr_en;
  logic              rd_en;

  assign wr_en = rst_n & CS & ~WEB;
  assign rd_en = rst_n & CS &  WEB;

  // Array contents survive reset; only the flags are invalidated.
  always_ff @(posedge clk) begin
    if (wr_en) mem[A] <= DI;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      written <= '0;
      dout_q  <= '0;
    end else if (wr_en) begin
      written[A] <= 1'b1;
      dout_q     <= DI;
    end else if (rd_en) begin
      dout_q <= written[A] ? mem[A] : '0;
    end
  end

  assign DO = OE ? dout_q : '0;

endmodule

// File: tb/tb_sram_sp_4096x16.sv
// Directed self-checking bench for sram_sp_4096x16: reset, write-through,
// readback, boundary addresses, CS/OE gating, read-after-write, mid-run reset.
module tb_sram_sp_4096x16;

  logic        clk;
  logic        rst_n;
  logic [11:0] A;
  logic [15:0] DI;
  logic [15:0] DO;
  logic        WEB;
  logic        CS;
  logic        OE;

  int checks;
  int failures;

  sram_sp_4096x16 dut (
    .clk(clk), .rst_n(rst_n), .A(A), .DI(DI), .DO(DO),
    .WEB(WEB), .CS(CS), .OE(OE)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Apply inputs, clock one edge, settle 1ns past the edge.
  task automatic cyc(input logic rn, input logic cs, input logic web,
                     input logic [11:0] a, input logic [15:0] di);
    rst_n = rn; CS = cs; WEB = web; A = a; DI = di;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    cyc(1'b0, 1'b0, 1'b1, 12'd0, 16'h0);
    cyc(1'b0, 1'b0, 1'b1, 12'd0, 16'h0);
    checks++;
    if (DO !== 16'h0000) begin failures++; $display("FAIL reset_do got=%h exp=0000", DO); end
    cyc(1'b1, 1'b1, 1'b1, 12'd0, 16'h0);
    checks++;
    if (DO !== 16'h0000) begin failures++; $display("FAIL reset_rd0 got=%h exp=0000", DO); end
    cyc(1'b1, 1'b1, 1'b1, 12'd4095, 16'h0);
    checks++;
    if (DO !== 16'h0000) begin failures++; $display("FAIL reset_rd4095 got=%h exp=0000", DO); end
  endtask

  task automatic test_seq;
    logic [15:0] pat [4];
    pat[0] = 16'h1111; pat[1] = 16'h2222; pat[2] = 16'h3333; pat[3] = 16'h4444;
    for (int i = 0; i < 4; i++) begin
      cyc(1'b1, 1'b1, 1'b0, 12'(i), pat[i]);
      checks++;
      if (DO !== pat[i]) begin failures++; $display("FAIL seq_wt a=%0d got=%h exp=%h", i, DO, pat[i]); end
    end
    for (int i = 0; i < 4; i++) begin
      cyc(1'b1, 1'b1, 1'b1, 12'(i), 16'hDEAD);
      checks++;
      if (DO !== pat[i]) begin failures++; $display("FAIL seq_rd a=%0d got=%h exp=%h", i, DO, pat[i]); end
    end
  endtask

  task automatic test_boundary;
    cyc(1'b1, 1'b1, 1'b0, 12'd4095, 16'hBEEF);
    cyc(1'b1, 1'b1, 1'b0, 12'd0, 16'hCAFE);
    cyc(1'b1, 1'b1, 1'b1, 12'd4095, 16'h0);
    checks++;
    if (DO !== 16'hBEEF) begin failures++; $display("FAIL bnd_rd4095 got=%h exp=beef", DO); end
    cyc(1'b1, 1'b1, 1'b1, 12'd0, 16'h0);
    checks++;
    if (DO !== 16'hCAFE) begin failures++; $display("FAIL bnd_rd0 got=%h exp=cafe", DO); end
    cyc(1'b1, 1'b1, 1'b1, 12'd1, 16'h0);
    checks++;
    if (DO !== 16'h2222) begin failures++; $display("FAIL bnd_rd1 got=%h exp=2222", DO); end
  endtask

  task automatic test_cs_oe;
    cyc(1'b1, 1'b1, 1'b1, 12'd4095, 16'h0);
    checks++;
    if (DO !== 16'hBEEF) begin failures++; $display("FAIL cs_pre got=%h exp=beef", DO); end
    for (int i = 0; i < 3; i++) begin
      cyc(1'b1, 1'b0, 1'b0, 12'd4095, 16'h0000);
      checks++;
      if (DO !== 16'hBEEF) begin failures++; $display("FAIL cs_hold cyc=%0d got=%h exp=beef", i, DO); end
    end
    cyc(1'b1, 1'b1, 1'b1, 12'd0, 16'h0);
    cyc(1'b1, 1'b1, 1'b1, 12'd4095, 16'h0);
    checks++;
    if (DO !== 16'hBEEF) begin failures++; $display("FAIL cs_noWrite got=%h exp=beef", DO); end
    OE = 1'b0; #1;
    checks++;
    if (DO !== 16'h0000) begin failures++; $display("FAIL oe_low got=%h exp=0000", DO); end
    OE = 1'b1; #1;
    checks++;
    if (DO !== 16'hBEEF) begin failures++; $display("FAIL oe_high got=%h exp=beef", DO); end
  endtask

  task automatic test_raw;
    cyc(1'b1, 1'b1, 1'b0, 12'd5, 16'h00AA);
    cyc(1'b1, 1'b1, 1'b1, 12'd6, 16'h0);
    checks++;
    if (DO !== 16'h0000) begin failures++; $display("FAIL raw_unwritten got=%h exp=0000", DO); end
    cyc(1'b1, 1'b1, 1'b1, 12'd5, 16'h0);
    checks++;
    if (DO !== 16'h00AA) begin failures++; $display("FAIL raw_rd got=%h exp=00aa", DO); end
    cyc(1'b1, 1'b1, 1'b0, 12'd5, 16'h00BB);
    cyc(1'b1, 1'b1, 1'b0, 12'd5, 16'h00CC);
    cyc(1'b1, 1'b1, 1'b1, 12'd5, 16'h0);
    checks++;
    if (DO !== 16'h00CC) begin failures++; $display("FAIL raw_lastwins got=%h exp=00cc", DO); end
  endtask

  task automatic test_reset_mid;
    cyc(1'b1, 1'b1, 1'b0, 12'd7, 16'h1234);
    checks++;
    if (DO !== 16'h1234) begin failures++; $display("FAIL rstm_wt got=%h exp=1234", DO); end
    cyc(1'b0, 1'b1, 1'b0, 12'd8, 16'h5678);
    checks++;
    if (DO !== 16'h0000) begin failures++; $display("FAIL rstm_do got=%h exp=0000", DO); end
    cyc(1'b1, 1'b1, 1'b1, 12'd7, 16'h0);
    checks++;
    if (DO !== 16'h0000) begin failures++; $display("FAIL rstm_rd7 got=%h exp=0000", DO); end
    cyc(1'b1, 1'b1, 1'b1, 12'd8, 16'h0);
    checks++;
    if (DO !== 16'h0000) begin failures++; $display("FAIL rstm_rd8 got=%h exp=0000", DO); end
    cyc(1'b1, 1'b1, 1'b1, 12'd4095, 16'h0);
    checks++;
    if (DO !== 16'h0000) begin failures++; $display("FAIL rstm_rd4095 got=%h exp=0000", DO); end
    cyc(1'b1, 1'b1, 1'b0, 12'd7, 16'h9ABC);
    cyc(1'b1, 1'b1, 1'b1, 12'd7, 16'h0);
    checks++;
    if (DO !== 16'h9ABC) begin failures++; $display("FAIL rstm_rewrite got=%h exp=9abc", DO); end
  endtask

  initial begin
    checks = 0; failures = 0;
    rst_n = 1'b0; CS = 1'b0; WEB = 1'b1; A = '0; DI = '0; OE = 1'b1;
    test_reset;
    test_seq;
    test_boundary;
    test_cs_oe;
    test_raw;
    test_reset_mid;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
